psum_mem_arbiter: RTL

Arbitrates the read port of the 1R1W partial-sum memory between two requesters: the convolution controller and a host drain port that reads finished output pixels. The controller's write port passes straight through to the memory. The block adds three things on top of that:

- tags each read so its data returns to the requester that issued it;
- forwards same-cycle writes to reads of the same address;
- optionally guarantees the host a read slot when it has been starved.

It sits between the controller FSM / datapad and the partial-sum SRAM macro.

---
 rtl/psum_mem_arbiter_if.sv | 44 ++++
 rtl/psum_mem_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/psum_mem_arbiter_if.sv
// Bus bundle between the partial-sum read arbiter, its two requesters and the SRAM macro.
// The slave side is the arbiter; the master side is everything around it.
interface psum_mem_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              ctrl_re;
    logic [ADDR_W-1:0] ctrl_raddr;
    logic              ctrl_we;
    logic [ADDR_W-1:0] ctrl_waddr;
    logic [DATA_W-1:0] ctrl_wdata;
    logic              ctrl_stall;
    logic              ctrl_rvalid;
    logic [DATA_W-1:0] ctrl_rdata;

    logic              host_req_valid;
    logic [ADDR_W-1:0] host_addr;
    logic              host_req_ready;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output ctrl_re, ctrl_raddr, ctrl_we, ctrl_waddr, ctrl_wdata,
        output host_req_valid, host_addr, mem_rdata,
        input  ctrl_stall, ctrl_rvalid, ctrl_rdata,
        input  host_req_ready, host_rvalid, host_rdata,
        input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  ctrl_re, ctrl_raddr, ctrl_we, ctrl_waddr, ctrl_wdata,
        input  host_req_valid, host_addr, mem_rdata,
        output ctrl_stall, ctrl_rvalid, ctrl_rdata,
        output host_req_ready, host_rvalid, host_rdata,
        output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/psum_mem_arbiter.sv
// Fixed-priority read arbiter for the 1R1W partial-sum SRAM with tagged returns and write forwarding.
// Optional host starvation guard is enabled by defining PSUM_ARB_STARVE_GUARD_EN.
module psum_mem_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 8
) (
    input logic              clk,
    input logic              rst_in,
    psum_mem_arbiter_if.slave bus
);
    localparam int LAST = READ_LATENCY - 1;

    logic              forced;
    logic              ctrlGrant;
    logic              hostGrant;
    logic [ADDR_W-1:0] issueAddr;
    logic              issueHit;
    logic [DATA_W-1:0] retData;

    logic [READ_LATENCY-1:0] tagValid_q;
    logic [READ_LATENCY-1:0] tagHost_q;
    logic [READ_LATENCY-1:0] tagHit_q;
    logic [DATA_W-1:0]       tagData_q [READ_LATENCY];

`ifdef PSUM_ARB_STARVE_GUARD_EN
    logic [7:0] starveCnt_q;
    logic [7:0] starveCnt_d;

    // A full run of MAX_WAIT denied host cycles turns the following cycle into a host slot.
    always_comb begin
        forced      = (starveCnt_q == 8'(MAX_WAIT));
        starveCnt_d = starveCnt_q + 8'd1;
        if (!bus.host_req_valid || hostGrant) begin
            starveCnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            starveCnt_q <= 8'd0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

    assign bus.ctrl_stall = !rst_in && forced && bus.ctrl_re;
`else
    assign forced         = 1'b0;
    assign bus.ctrl_stall = 1'b0;
`endif

    always_comb begin
        ctrlGrant = !rst_in && bus.ctrl_re && !forced;
        hostGrant = !rst_in && bus.host_req_valid && (forced || !bus.ctrl_re);
        issueAddr = ctrlGrant ? bus.ctrl_raddr : bus.host_addr;
        issueHit  = bus.ctrl_we && (issueAddr == bus.ctrl_waddr);
    end

    assign bus.mem_re         = ctrlGrant || hostGrant;
    assign bus.mem_raddr      = issueAddr;
    assign bus.host_req_ready = hostGrant;
    assign bus.mem_we         = bus.ctrl_we && !rst_in;
    assign bus.mem_waddr      = bus.ctrl_waddr;
    assign bus.mem_wdata      = bus.ctrl_wdata;

    // The SRAM returns old data on a same-address write, so the new word rides along in the tag.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            tagValid_q <= '0;
            tagHost_q  <= '0;
            tagHit_q   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tagData_q[i] <= '0;
            end
        end else begin
            tagValid_q[0] <= bus.mem_re;
            tagHost_q[0]  <= hostGrant;
            tagHit_q[0]   <= issueHit;
            tagData_q[0]  <= bus.ctrl_wdata;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagHost_q[i]  <= tagHost_q[i-1];
                tagHit_q[i]   <= tagHit_q[i-1];
                tagData_q[i]  <= tagData_q[i-1];
            end
        end
    end

    assign retData         = tagHit_q[LAST] ? tagData_q[LAST] : bus.mem_rdata;
    assign bus.ctrl_rvalid = !rst_in && tagValid_q[LAST] && !tagHost_q[LAST];
    assign bus.host_rvalid = !rst_in && tagValid_q[LAST] && tagHost_q[LAST];
    assign bus.ctrl_rdata  = retData;
    assign bus.host_rdata  = retData;
endmodule
